// File: rtl/mmio_result_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_result_tx_if
// Purpose  : External memory bus signals shared by the CPU and the
//            memory-mapped result port.
// Ports    : mem_we   - write strobe              (CPU -> port)
//            mem_addr - bus address               (CPU -> port)
//            mem_din  - write data                (CPU -> port)
//            rd_data  - registered read data      (port -> CPU)
//            hit      - registered window select  (port -> CPU)
// Revision : 1.0  initial release
// ============================================================================
interface mmio_result_tx_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 24
);
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  hit;

   modport master (output mem_we, mem_addr, mem_din, input  rd_data, hit);
   modport slave  (input  mem_we, mem_addr, mem_din, output rd_data, hit);
endinterface
`default_nettype wire

// File: rtl/mmio_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_result_tx
// Purpose  : Memory-mapped result port. CPU stores to TXDATA are queued in a
//            word FIFO and shifted out of a UART pin (8N1, 3 bytes per word,
//            MSB byte first). STATUS reads return {overflow, full, busy}.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            bus      - memory bus (slave modport)
//            tx       - UART serial output, idle high
//            busy     - FIFO non-empty or frame in flight
//            overflow - sticky: a TXDATA write was dropped on a full FIFO
// Revision : 1.0  initial release
// ============================================================================
module mmio_result_tx #(
   parameter int                    ADDR_WIDTH   = 14,
   parameter int                    DATA_WIDTH   = 24,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 14'h3FF0,
   parameter int                    CLKS_PER_BIT = 868,
   parameter int                    FIFO_DEPTH   = 16
) (
   input  wire                    clk,
   input  wire                    rst_n,
   mmio_result_tx_if.slave        bus,
   output logic                   tx,
   output logic                   busy,
   output logic                   overflow
);
   localparam int                    PTR_W       = $clog2(FIFO_DEPTH);
   localparam int                    BAUD_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(1);
   localparam logic [BAUD_W-1:0]     BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

   // ---------------------------------------------------------------- FIFO
   logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
   logic                  w_empty, w_full, w_wr_data, w_push, w_drop, w_clr, w_pop;
   logic                  r_overflow;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_wr_data = bus.mem_we && (bus.mem_addr == BASE_ADDR);
   // Full is judged on the pre-edge state, so a pop on the same edge does
   // not make room for the incoming word.
   assign w_push    = w_wr_data && !w_full;
   assign w_drop    = w_wr_data &&  w_full;
   assign w_clr     = bus.mem_we && (bus.mem_addr == STATUS_ADDR) && bus.mem_din[0];

   always_ff @(posedge clk) begin
      if (w_push) r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= bus.mem_din;
   end

   // ---------------------------------------------------------------- UART FSM
   state_t           r_state, w_state_nxt;
   logic [BAUD_W-1:0] r_baud, w_baud_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [23:0]      r_word, w_word_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic             r_tx, w_tx_nxt;
   logic             w_baud_end;

   assign w_baud_end = (r_baud == BAUD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_idx_nxt   = r_idx;
      w_word_nxt  = r_word;
      w_byte_nxt  = r_byte;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_word_nxt  = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
               w_idx_nxt   = 2'd0;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            case (r_idx)
               2'd0:    w_byte_nxt = r_word[23:16];
               2'd1:    w_byte_nxt = r_word[15:8];
               default: w_byte_nxt = r_word[7:0];
            endcase
            w_baud_nxt  = '0;
            w_state_nxt = S_START;
         end
         S_START: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = 3'd0;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) w_state_nxt = S_STOP;
               else               w_bit_nxt   = r_bit + 3'd1;
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_idx != 2'd2) begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = S_LOAD;
               end else if (!w_empty) begin
                  // Next word follows straight on; only the LOAD cycle separates them.
                  w_pop       = 1'b1;
                  w_word_nxt  = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
                  w_idx_nxt   = 2'd0;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Line level is registered from the next state so tx never glitches.
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_byte_nxt[w_bit_nxt];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_baud       <= '0;
         r_bit        <= '0;
         r_idx        <= '0;
         r_word       <= '0;
         r_byte       <= '0;
         r_tx         <= 1'b1;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_overflow   <= 1'b0;
         bus.rd_data  <= '0;
         bus.hit      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bit    <= w_bit_nxt;
         r_idx    <= w_idx_nxt;
         r_word   <= w_word_nxt;
         r_byte   <= w_byte_nxt;
         r_tx     <= w_tx_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
         // A drop on the same edge as a clear leaves the flag set.
         if (w_drop)     r_overflow <= 1'b1;
         else if (w_clr) r_overflow <= 1'b0;
         bus.rd_data <= (bus.mem_addr == STATUS_ADDR) ?
                        {{(DATA_WIDTH-3){1'b0}}, r_overflow, w_full, busy} : '0;
         bus.hit     <= (bus.mem_addr == BASE_ADDR) || (bus.mem_addr == STATUS_ADDR);
      end
   end

   assign tx       = r_tx;
   assign busy     = !w_empty || (r_state != S_IDLE);
   assign overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_mmio_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_result_tx
// Purpose  : Directed bench for mmio_result_tx with a UART receive model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_result_tx;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [13:0] BASE  = 14'h3FF0;
   localparam logic [13:0] STAT  = 14'h3FF1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tx, busy, overflow;

   mmio_result_tx_if #(.ADDR_WIDTH(14), .DATA_WIDTH(24)) bus ();

   mmio_result_tx #(
      .ADDR_WIDTH(14), .DATA_WIDTH(24), .BASE_ADDR(BASE),
      .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .tx       (tx),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------- UART model
   logic [7:0] rx_q   [$];
   int         fall_q [$];
   logic [7:0] exp_q  [$];
   logic [7:0] mon_sh;
   int         mon_cnt = -1;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_cnt = -1;
      end else if (mon_cnt < 0) begin
         if (tx === 1'b0) begin
            mon_cnt = 0;
            fall_q.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % 4) == 0)
            mon_sh[(mon_cnt - 5) / 4] = tx;
         if (mon_cnt == 37) begin
            check("stop_bit", {31'b0, tx}, 32'd1);
            rx_q.push_back(mon_sh);
         end
         if (mon_cnt == 39) mon_cnt = -1;
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic bus_write(input logic [13:0] a, input logic [23:0] d, output int n);
      @(negedge clk);
      bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_din = d;
      @(negedge clk);
      bus.mem_we = 1'b0; bus.mem_addr = 14'h0; bus.mem_din = 24'h0;
      n = cyc;
   endtask

   task automatic bus_read(input logic [13:0] a, output logic [23:0] d, output logic h);
      @(negedge clk);
      bus.mem_we = 1'b0; bus.mem_addr = a;
      @(negedge clk);
      d = bus.rd_data; h = bus.hit;
      bus.mem_addr = 14'h0;
   endtask

   task automatic wait_idle(input int limit);
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic expect_word(input logic [23:0] w);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   // Compares decoded bytes and requires every frame to start exactly one
   // LOAD cycle after the previous frame's stop bit (10*CPB + 1 cycles apart).
   task automatic check_rx(input string tag);
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
      for (int i = 1; i < fall_q.size(); i++)
         check({tag, "_gap"}, fall_q[i] - fall_q[i-1], 10 * CPB + 1);
      rx_q.delete(); fall_q.delete(); exp_q.delete();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [23:0] rd;
      logic        h;
      int          n0, n1;

      bus.mem_we = 1'b0; bus.mem_addr = 14'h0; bus.mem_din = 24'h0;

      // 1. reset state and quiet idle
      repeat (3) @(negedge clk);
      check("rst_tx",   {31'b0, tx},       32'd1);
      check("rst_busy", {31'b0, busy},     32'd0);
      check("rst_ovf",  {31'b0, overflow}, 32'd0);
      check("rst_rd",   {8'b0, bus.rd_data}, 32'd0);
      check("rst_hit",  {31'b0, bus.hit},  32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle_line", {6'b0, tx, busy, bus.rd_data}, {6'b0, 1'b1, 1'b0, 24'h0});
      end

      // 2. single word, latency and busy timing
      bus_write(BASE, 24'hA5C3F0, n0);
      repeat (123) @(negedge clk);
      check("busy_last", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("busy_drop", {31'b0, busy}, 32'd0);
      check("first_fall", fall_q.size() > 0 ? fall_q[0] - n0 : -1, 32'd2);
      expect_word(24'hA5C3F0);
      check_rx("single");

      // 3. six words on consecutive cycles: 1 popped, 4 queued, 6th dropped
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         bus.mem_we = 1'b1; bus.mem_addr = BASE; bus.mem_din = 24'(i);
      end
      bus_read(STAT, rd, h);
      check("stat_full", {8'b0, rd}, 32'h7);
      check("stat_hit",  {31'b0, h}, 32'd1);
      wait_idle(1000);
      check("ovf_set", {31'b0, overflow}, 32'd1);
      for (int i = 1; i <= 5; i++) expect_word(24'(i));
      check_rx("burst");

      // 4. overflow clear, BASE read, out-of-window accesses
      bus_read(STAT, rd, h);
      check("stat_ovf", {8'b0, rd}, 32'h4);
      bus_write(STAT, 24'h000001, n1);
      bus_read(STAT, rd, h);
      check("stat_clr", {8'b0, rd}, 32'h0);
      bus_read(BASE, rd, h);
      check("base_rd",  {8'b0, rd}, 32'h0);
      check("base_hit", {31'b0, h}, 32'd1);
      bus_write(BASE + 14'd2, 24'h111111, n1);
      bus_write(BASE - 14'd1, 24'h222222, n1);
      check("oow_busy", {31'b0, busy}, 32'd0);
      bus_read(BASE + 14'd2, rd, h);
      check("oow_hi_hit", {31'b0, h}, 32'd0);
      bus_read(BASE - 14'd1, rd, h);
      check("oow_lo_hit", {31'b0, h}, 32'd0);
      repeat (50) @(negedge clk);
      check("oow_nobytes", rx_q.size(), 32'd0);

      // 5. reset mid-DATA of byte 2 with a second word queued
      bus_write(BASE, 24'hFF00FF, n0);
      bus_write(BASE, 24'h777777, n1);
      repeat (54) @(negedge clk);
      check("pre_rst_tx", {31'b0, tx}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_tx",   {31'b0, tx},   32'd1);
      check("abort_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete(); fall_q.delete();
      @(negedge clk);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      repeat (60) @(negedge clk);
      check("discarded", rx_q.size(), 32'd0);
      bus_write(BASE, 24'h123456, n0);
      wait_idle(400);
      expect_word(24'h123456);
      check_rx("after_rst");

      // 6. two words back to back
      bus_write(BASE, 24'hABCDEF, n0);
      bus_write(BASE, 24'h13579B, n1);
      wait_idle(600);
      expect_word(24'hABCDEF);
      expect_word(24'h13579B);
      check_rx("b2b");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
